// File: rtl/apb_pkg.sv
// Shared APB types: FSM states, default bus widths and command/response bundles.
// Used by the master, the slave-side memory and the benches.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

   // Wait-counter width: enough to hold TIMEOUT_CYCLES, never below one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles <= 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/apb_master.sv
// APB requester: takes one command at a time from a valid/ready port, runs
// SETUP/ACCESS, and reports completion, slave error or timeout on a 1-cycle strobe.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int              CNT_W    = cnt_width(TIMEOUT_CYCLES);
   localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   apb_state_e       state, state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic             accept, done, abort;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   // Bus control is decoded from state alone so reset drops PSEL/PENABLE at once.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      cmd_ready = 1'b0;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            PSEL      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            // PREADY takes priority over a timeout landing on the same cycle.
            if (PREADY) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (TO_EN && wait_cnt == CNT_LAST) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         wait_cnt <= '0;
      else if (state == SETUP)
         wait_cnt <= '0;
      else if (state == ACCESS && !done && !abort && wait_cnt != CNT_MAX)
         wait_cnt <= wait_cnt + 1'b1;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= done | abort;
         if (accept) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
         end
         if (done) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
         end else if (abort) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
         end
      end
   end

endmodule
